au_cmd_issuer: RTL and testbench

//  Initiator/collector for the combinational 4-bit arithmetic unit (add/sub/mul/div).

---
 rtl/au_cmd_issuer.sv | 213 +++++++++++++++++++++
 tb/tb_au_cmd_issuer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_cmd_issuer.sv
// au_cmd_issuer: queues add/sub/mul/div commands, drives them one at a time
// onto the combinational arithmetic unit and returns the captured result.
module au_cmd_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_a,
  input  logic [3:0]             cmd_b,
  input  logic [1:0]             cmd_op,
  output logic [3:0]             au_a,
  output logic [3:0]             au_b,
  output logic [1:0]             au_c,
  input  logic [7:0]             au_o,
  input  logic [7:0]             au_o1,
  input  logic [7:0]             au_o2,
  input  logic [7:0]             au_o3,
  input  logic [7:0]             au_o4,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_data,
  output logic [7:0]             res_rem,
  output logic [1:0]             res_op,
  output logic                   res_dz,
  output logic                   res_chk,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TSET = TW'(SETTLE);
  localparam logic [TW-1:0] TONE = TW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          busy_q, busy_d;
  logic [3:0]    au_a_q, au_a_d;
  logic [3:0]    au_b_q, au_b_d;
  logic [1:0]    au_c_q, au_c_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [7:0]    res_rem_q, res_rem_d;
  logic [1:0]    res_op_q, res_op_d;
  logic          res_dz_q, res_dz_d;
  logic          res_chk_q, res_chk_d;

  logic [9:0] mem_q [DEPTH];
  logic [9:0] head;
  logic       push;
  logic       pop;
  logic [7:0] cap_data;
  logic [7:0] cap_rem;
  logic       cap_dz;
  logic       cap_chk;

  assign cmd_ready = !rst && (count_q < FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
  end

  // Result selection from the unit buses for the operand set now on au_*
  always_comb begin
    cap_dz   = (au_c_q == 2'b11) && (au_b_q == 4'd0);
    cap_data = '0;
    cap_rem  = '0;
    cap_chk  = 1'b0;
    unique case (au_c_q)
      2'b00: begin
        cap_data = au_o;
        cap_chk  = |{au_o1, au_o2, au_o3, au_o4};
      end
      2'b01: begin
        cap_data = au_o1;
        cap_chk  = |{au_o, au_o2, au_o3, au_o4};
      end
      2'b10: begin
        cap_data = au_o2;
        cap_chk  = |{au_o, au_o1, au_o3, au_o4};
      end
      2'b11: begin
        cap_data = au_o3;
        cap_rem  = au_o4;
        cap_chk  = |{au_o, au_o1, au_o2};
      end
    endcase
    if (cap_dz) begin
      cap_data = '0;
      cap_rem  = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    au_a_d      = au_a_q;
    au_b_d      = au_b_q;
    au_c_d      = au_c_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rem_d   = res_rem_q;
    res_op_d    = res_op_q;
    res_dz_d    = res_dz_q;
    res_chk_d   = res_chk_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          au_a_d  = head[9:6];
          au_b_d  = head[5:2];
          au_c_d  = head[1:0];
          timer_d = TSET;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == TONE) begin
          res_valid_d = 1'b1;
          res_data_d  = cap_data;
          res_rem_d   = cap_rem;
          res_op_d    = au_c_q;
          res_dz_d    = cap_dz;
          res_chk_d   = cap_chk;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      au_a_q      <= '0;
      au_b_q      <= '0;
      au_c_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rem_q   <= '0;
      res_op_q    <= '0;
      res_dz_q    <= 1'b0;
      res_chk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      au_a_q      <= au_a_d;
      au_b_q      <= au_b_d;
      au_c_q      <= au_c_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rem_q   <= res_rem_d;
      res_op_q    <= res_op_d;
      res_dz_q    <= res_dz_d;
      res_chk_q   <= res_chk_d;
    end
  end

  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_c      = au_c_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rem   = res_rem_q;
  assign res_op    = res_op_q;
  assign res_dz    = res_dz_q;
  assign res_chk   = res_chk_q;
  assign busy      = busy_q;
  assign count     = count_q;

endmodule

// File: tb/tb_au_cmd_issuer.sv
// Bench for au_cmd_issuer: combinational unit model, vector table,
// directed corner sequences and a randomized run against a reference queue.
module tb_au_cmd_issuer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic [1:0] au_c;
  logic [7:0] au_o, au_o1, au_o2, au_o3, au_o4;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [7:0] res_rem;
  logic [1:0] res_op;
  logic       res_dz;
  logic       res_chk;
  logic       busy;
  logic [$clog2(DEPTH):0] count;

  au_cmd_issuer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .au_a(au_a), .au_b(au_b), .au_c(au_c),
    .au_o(au_o), .au_o1(au_o1), .au_o2(au_o2),
    .au_o3(au_o3), .au_o4(au_o4),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rem(res_rem), .res_op(res_op),
    .res_dz(res_dz), .res_chk(res_chk),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Arithmetic unit: only the bus selected by au_c is driven nonzero
  logic [7:0] inj_o2 = '0;
  always_comb begin
    au_o  = '0;
    au_o1 = '0;
    au_o2 = inj_o2;
    au_o3 = '0;
    au_o4 = '0;
    case (au_c)
      2'd0: au_o = 8'(au_a) + 8'(au_b);
      2'd1: au_o1 = 8'(au_a) - 8'(au_b);
      2'd2: au_o2 = inj_o2 | (8'(au_a) * 8'(au_b));
      default: begin
        if (au_b == 4'd0) begin
          au_o3 = 8'hFF;
          au_o4 = 8'(au_a);
        end else begin
          au_o3 = 8'(au_a / au_b);
          au_o4 = 8'(au_a % au_b);
        end
      end
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] rem;
    logic       dz;
    logic       chk;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] rem;
    logic       dz;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  bit   prod_done = 1'b0;
  exp_t exp_q [$];

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  function automatic exp_t model(int a, int b, int op, int inj);
    exp_t e;
    e.op   = 2'(op);
    e.rem  = '0;
    e.dz   = 1'b0;
    e.chk  = (inj != 0) && (op != 2);
    e.data = '0;
    case (op)
      0: e.data = 8'(a + b);
      1: e.data = 8'(a - b);
      2: e.data = 8'(a * b);
      default: begin
        if (b == 0) e.dz = 1'b1;
        else begin
          e.data = 8'(a / b);
          e.rem  = 8'(a % b);
        end
      end
    endcase
    return e;
  endfunction

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op);
    bit acc;
    acc = 1'b0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!acc) check("push timeout", 32'd0, 32'd1);
    else if (mon_en) exp_q.push_back(model(a, b, op, inj_o2));
  endtask

  task automatic wait_res(string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check({nm, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic collect(string nm, exp_t e);
    bit ok;
    wait_res(nm, ok);
    if (ok) begin
      check({nm, " data"}, 32'(res_data), 32'(e.data));
      check({nm, " rem"}, 32'(res_rem), 32'(e.rem));
      check({nm, " op"}, 32'(res_op), 32'(e.op));
      check({nm, " dz"}, 32'(res_dz), 32'(e.dz));
      check({nm, " chk"}, 32'(res_chk), 32'(e.chk));
      @(posedge clk);
      #1;
    end
  endtask

  // Random-phase monitor: result order and hold-until-accepted
  exp_t        mon_e;
  bit          hold = 1'b0;
  logic [19:0] hold_v;
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold) begin
        check("rand valid held", 32'(res_valid), 32'd1);
        check("rand stable",
              32'({res_data, res_rem, res_op, res_dz, res_chk}),
              32'(hold_v));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("rand unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("rand data", 32'(res_data), 32'(mon_e.data));
          check("rand rem", 32'(res_rem), 32'(mon_e.rem));
          check("rand op", 32'(res_op), 32'(mon_e.op));
          check("rand dz", 32'(res_dz), 32'(mon_e.dz));
          check("rand chk", 32'(res_chk), 32'(mon_e.chk));
        end
      end
      hold   = res_valid && !res_ready;
      hold_v = {res_data, res_rem, res_op, res_dz, res_chk};
    end else hold = 1'b0;
  end

  vec_t tbl [11];
  exp_t q3 [$];
  exp_t e;
  bit   ok;
  bit   stable;
  int   cyc;

  initial begin
    tbl[0]  = '{4'd9,  4'd7,  2'd0, 8'h10, 8'h00, 1'b0};
    tbl[1]  = '{4'd13, 4'd4,  2'd3, 8'h03, 8'h01, 1'b0};
    tbl[2]  = '{4'd5,  4'd0,  2'd3, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{4'd3,  4'd5,  2'd1, 8'hFE, 8'h00, 1'b0};
    tbl[4]  = '{4'd15, 4'd15, 2'd2, 8'hE1, 8'h00, 1'b0};
    tbl[5]  = '{4'd15, 4'd15, 2'd0, 8'h1E, 8'h00, 1'b0};
    tbl[6]  = '{4'd0,  4'd15, 2'd1, 8'hF1, 8'h00, 1'b0};
    tbl[7]  = '{4'd15, 4'd1,  2'd3, 8'h0F, 8'h00, 1'b0};
    tbl[8]  = '{4'd7,  4'd3,  2'd3, 8'h02, 8'h01, 1'b0};
    tbl[9]  = '{4'd0,  4'd0,  2'd3, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{4'd12, 4'd13, 2'd2, 8'h9C, 8'h00, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst au", 32'({au_a, au_b, au_c}), 32'd0);
    check("rst res", 32'({res_data, res_rem, res_op, res_dz, res_chk}), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

    // Latency of a single add
    res_ready = 1'b1;
    cmd_a = 4'd9;
    cmd_b = 4'd7;
    cmd_op = 2'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("lat E count", 32'(count), 32'd1);
    check("lat E busy", 32'(busy), 32'd1);
    check("lat E valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat E+1 valid", 32'(res_valid), 32'd0);
    check("lat E+1 au", 32'({au_a, au_b, au_c}), 32'({4'd9, 4'd7, 2'd0}));
    @(posedge clk);
    #1;
    check("lat E+2 valid", 32'(res_valid), 32'd1);
    collect("lat", model(9, 7, 0, 0));
    check("lat done valid", 32'(res_valid), 32'd0);

    // Vector table
    foreach (tbl[i]) begin
      push(tbl[i].a, tbl[i].b, tbl[i].op);
      e.op = tbl[i].op;
      e.data = tbl[i].data;
      e.rem = tbl[i].rem;
      e.dz = tbl[i].dz;
      e.chk = 1'b0;
      collect($sformatf("tbl%0d", i), e);
    end

    // Back-to-back offers with consumer stalled
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 4'(i + 1);
      cmd_b = 4'(i);
      cmd_op = 2'd0;
      cmd_valid = 1'b1;
      if (cmd_ready) q3.push_back(model(i + 1, i, 0, 0));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("b2b accepted", 32'(q3.size()), 32'd5);
    check("b2b count", 32'(count), 32'(DEPTH));
    check("b2b cmd_ready", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    while (q3.size() > 0) collect("b2b", q3.pop_front());
    check("b2b drained", 32'({busy, count}), 32'd0);

    // Result held under backpressure
    res_ready = 1'b0;
    push(4'd3, 4'd5, 2'd1);
    wait_res("hold", ok);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_data != 8'hFE) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    check("hold stable", 32'(stable), 32'd1);
    check("hold data", 32'(res_data), 32'hFE);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold release", 32'(res_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold single", 32'({res_valid, busy}), 32'd0);

    // Nonzero non-selected bus
    inj_o2 = 8'h01;
    push(4'd1, 4'd1, 2'd0);
    collect("chk", model(1, 1, 0, 1));
    inj_o2 = 8'h00;

    // Reset while in WAIT with two queued
    res_ready = 1'b0;
    push(4'd1, 4'd2, 2'd0);
    push(4'd2, 4'd2, 2'd0);
    push(4'd3, 4'd2, 2'd0);
    push(4'd4, 4'd2, 2'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst handshake", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("mid rst pre count", 32'(count), 32'd2);
    check("mid rst pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst valid", 32'(res_valid), 32'd0);
    check("mid rst count", 32'(count), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    push(4'd2, 4'd3, 2'd2);
    collect("after rst", model(2, 3, 2, 0));
    repeat (4) @(posedge clk);
    #1;
    check("after rst idle", 32'({res_valid, busy, count}), 32'd0);

    // Randomized traffic against the reference queue
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)));
        end
        prod_done = 1'b1;
      end
      begin
        cyc = 0;
        while (!(prod_done && exp_q.size() == 0 && !res_valid) &&
               cyc < 5000) begin
          @(posedge clk);
          #1;
          res_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        if (cyc >= 5000) check("rand timeout", 32'd0, 32'd1);
      end
    join
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rand end idle", 32'({res_valid, busy, count}), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
